// File: rtl/tt_activity_pkg.sv
// Shared types and constants for the activity monitor display block.
package tt_activity_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [3:0] {
    MODE_HEX = 4'd0,
    MODE_SE  = 4'd1,
    MODE_SC  = 4'd2
  } mode_e;

  // Common-cathode segment patterns, bit0 = segment a.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to 7-segment pattern, purely combinational.
module seg7_decoder
  import tt_activity_pkg::*;
(
  input  nibble_t    digit,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern.
  always_comb begin
    seg = SEG_LUT[digit];
  end

endmodule

// File: rtl/tt_activity_monitor.sv
// Activity monitor: free-running hex digit or scan_en / scan_clk rise counts
// on a 7-segment display, selected by a synchronized mode nibble.
module tt_activity_monitor
  import tt_activity_pkg::*;
#(
  parameter int unsigned DIV         = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic clk;
  logic rstn;

  assign clk  = io_in[0];
  assign rstn = io_in[2];

  logic [SYNC_STAGES-1:0] sc_sync;
  logic [SYNC_STAGES-1:0] se_sync;
  nibble_t                mode_sync [SYNC_STAGES];

  logic    sync_scan_clk;
  logic    sync_scan_en;
  nibble_t sync_mode;

  logic sc_prev;
  logic se_prev;
  logic sc_rise;
  logic se_rise;

  logic [PW-1:0] pre_cnt;
  logic          tick;

  nibble_t hex_cnt;
  nibble_t se_cnt;
  nibble_t sc_cnt;
  logic    dp_q;

  nibble_t    disp;
  logic       dp_out;
  logic [6:0] seg;

  assign sync_scan_clk = sc_sync[SYNC_STAGES-1];
  assign sync_scan_en  = se_sync[SYNC_STAGES-1];
  assign sync_mode     = mode_sync[SYNC_STAGES-1];

  assign sc_rise = sync_scan_clk & ~sc_prev;
  assign se_rise = sync_scan_en  & ~se_prev;
  assign tick    = (pre_cnt == PRE_MAX);

  // Input synchronizer chains plus one edge-detect history flop per signal.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sc_sync <= '0;
      se_sync <= '0;
      sc_prev <= 1'b0;
      se_prev <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        mode_sync[i] <= '0;
      end
    end else begin
      sc_sync      <= {sc_sync[SYNC_STAGES-2:0], io_in[1]};
      se_sync      <= {se_sync[SYNC_STAGES-2:0], io_in[3]};
      sc_prev      <= sync_scan_clk;
      se_prev      <= sync_scan_en;
      mode_sync[0] <= io_in[7:4];
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        mode_sync[i] <= mode_sync[i-1];
      end
    end
  end

  // Prescaler, hex counter with dp toggle, and the two activity counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pre_cnt <= '0;
      hex_cnt <= '0;
      dp_q    <= 1'b0;
      se_cnt  <= '0;
      sc_cnt  <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        hex_cnt <= hex_cnt + 4'd1;
        dp_q    <= ~dp_q;
      end
      if (se_rise) begin
        se_cnt <= se_cnt + 4'd1;
      end
      if (sc_rise) begin
        sc_cnt <= sc_cnt + 4'd1;
      end
    end
  end

  // Display source and decimal point selection by synchronized mode.
  always_comb begin
    disp   = sync_mode;
    dp_out = 1'b0;
    case (sync_mode)
      MODE_HEX: begin
        disp   = hex_cnt;
        dp_out = dp_q;
      end
      MODE_SE: begin
        disp   = se_cnt;
        dp_out = sync_scan_en;
      end
      MODE_SC: begin
        disp   = sc_cnt;
        dp_out = sync_scan_en;
      end
      default: begin
        disp   = sync_mode;
        dp_out = 1'b0;
      end
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .digit (disp),
    .seg   (seg)
  );

  assign io_out = {dp_out, seg};

endmodule

// File: tb/tb_tt_activity_monitor.sv
// Directed bench for tt_activity_monitor with hand-computed display values.
module tb_tt_activity_monitor;

  localparam logic [6:0] SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       clk = 1'b0;
  logic       rstn;
  logic       scan_clk;
  logic       scan_en;
  logic [3:0] mode;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  assign io_in = {mode, scan_en, rstn, scan_clk, clk};

  tt_activity_monitor #(
    .DIV         (16),
    .SYNC_STAGES (2)
  ) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (io_out === exp)
    else begin
      errors++;
      $error("FAIL %s: io_out=%02h expected %02h", tag, io_out, exp);
    end
  endtask

  initial begin
    logic [7:0] exp;
    int unsigned cnt;
    logic dp;

    rstn     = 1'b0;
    scan_clk = 1'b0;
    scan_en  = 1'b0;
    mode     = 4'h0;

    // Reset held for 5 edges.
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("reset", 8'h3F);
    end
    rstn = 1'b1;
    step(1);
    check("release_edge1", 8'h3F);

    // Hex counting: first tick on the 16th edge after release.
    step(14);
    check("hex_edge15", 8'h3F);
    step(1);
    check("hex_edge16", 8'h86);
    step(16);
    check("hex_edge32", 8'h5B);
    step(223);
    check("hex_edge255", 8'hF1);
    step(1);
    check("hex_wrap256", 8'h3F);

    // Reach digit 9 (25 ticks since release, dp set), then reset for 1 cycle.
    step(144);
    check("hex_digit9", 8'hEF);
    rstn = 1'b0;
    step(1);
    check("midrun_reset", 8'h3F);
    rstn = 1'b1;
    step(15);
    check("post_reset_edge15", 8'h3F);
    step(1);
    check("post_reset_edge16", 8'h86);

    // Scan-enable count in mode 1.
    mode = 4'h1;
    step(2);
    check("mode1_initial", 8'h3F);
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 8; k++) begin
        scan_en = (k <= 4);
        step(1);
        cnt = p + ((k >= 3) ? 1 : 0);
        dp  = (k >= 2) && (k <= 5);
        exp = {dp, SEG[cnt]};
        check("se_pulse", exp);
      end
    end
    check("se_count3", 8'h4F);

    // Scan-clock count in mode 2: toggle every 2 cycles, 5 rises.
    mode = 4'h2;
    step(2);
    check("mode2_initial", 8'h3F);
    for (int k = 0; k < 10; k++) begin
      scan_clk = ~scan_clk;
      step(2);
    end
    check("sc_count5", 8'h6D);
    step(2);
    check("sc_count_hold", 8'h6D);

    // Mode passthrough and return to hex display.
    mode = 4'hA;
    step(1);
    check("mode_sync_lag", 8'h6D);
    step(1);
    check("mode_A", 8'h77);
    mode = 4'h0;
    step(2);
    check("hex_resume70", 8'h66);
    step(9);
    check("hex_edge79", 8'h66);
    step(1);
    check("hex_edge80", 8'hED);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
